rf_wb_queue: RTL and testbench
==============================

// Module: rf_wb_queue
// PURPOSE
//  Write-side initiator for the register file: collects register writebacks from two producers
//  (A = main pipeline, B = multi-cycle unit) and drives the single RF write port (wen/waddr/wdata).
//  - Requests are ordered in a small in-order FIFO, one RF write per granted cycle.
//  - Pending-write flags let decode stall on registers that still have queued writes.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >= 2
// PORTS
//  i_clk        in   1        global clock, rising edge
//  i_rst_n      in   1        asynchronous active-low reset
//  i_a_valid    in   1        producer A write request
//  o_a_ready    out  1        A request accepted this edge when valid&ready
//  i_a_waddr    in   5        A destination register
//  i_a_wdata    in   32       A write data
//  i_b_valid    in   1        producer B write request
//  o_b_ready    out  1        B request accepted this edge when valid&ready
//  i_b_waddr    in   5        B destination register
//  i_b_wdata    in   32       B write data
//  i_wb_grant   in   1        RF write port available this cycle
//  o_rd_wen     out  1        RF write enable
//  o_rd_waddr   out  5        RF write address (queue head)
//  o_rd_wdata   out  32       RF write data (queue head)
//  i_rs1_chk    in   5        decode rs1 address for hazard query
//  i_rs2_chk    in   5        decode rs2 address for hazard query
//  o_rs1_pend   out  1        a queued entry targets i_rs1_chk
//  o_rs2_pend   out  1        a queued entry targets i_rs2_chk
//  o_count      out  clog2(DEPTH)+1  valid entries
//  o_full       out  1        count == DEPTH
//  o_empty      out  1        count == 0
// BEHAVIOUR
//  - Reset (async, while i_rst_n=0): rd/wr pointers=0, count=0, o_empty=1, o_full=0,
//    o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, o_a_ready=0, o_b_ready=0, pend flags=0.
//    Reset mid-operation discards all queued entries immediately; no RF write occurs.
//  - Push: o_a_ready = !full; o_b_ready = !full & !i_a_valid (A has fixed priority).
//    At most one push per edge; producer holds valid/addr/data stable until accepted.
//  - Pop: o_rd_wen = !empty & i_wb_grant (combinational from grant).
//    o_rd_waddr/o_rd_wdata = head entry, forced 0 when empty. Head retires on an edge with o_rd_wen=1.
//  - Latency: entry accepted at edge N is visible at the head no earlier than the cycle after N.
//    With an empty queue and constant grant, the RF is written at edge N+1. No same-cycle bypass.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//    When full, push is refused even if a pop occurs in the same cycle.
//  - Pointers wrap modulo DEPTH. Order is strictly FIFO, so later writes to the same register
//    land last.
//  - oN_pend = (chk != 0) & any valid entry (head included) has waddr == chk.
//    The flag drops in the cycle after the last matching entry retires.
// CONFIGURATION
//  RF_WBQ_DROP_X0_EN defined: a request with waddr==0 is accepted (ready per rules above) but not
//    enqueued; count, pointers and the RF port are unaffected.
//  Not defined: x0 requests are queued and written like any other; the RF discards the write.
// TESTING
//  1. Load 3 entries, grant=0, pulse i_rst_n=0 between edges -> o_count=0, o_empty=1,
//     o_rd_wen=0 immediately; after release no RF write.
//  2. grant=1, A push x5=32'hDEADBEEF at edge 1 -> cycle after: o_rd_wen=1, waddr=5,
//     wdata=DEADBEEF; after edge 2 o_empty=1.
//  3. A x1=32'h11 and B x2=32'h22 both valid -> o_b_ready=0, A taken edge 1, B taken edge 2;
//     RF writes x1 then x2.
//  4. grant=0, push 4 A writes (DEPTH=4) -> o_full=1, o_a_ready=0, 5th held.
//     Grant 1 cycle with 5th valid -> 1 pop, 5th still refused that edge, accepted the next.
//  5. grant=0, queue x7 -> o_rs1_pend=1 for chk=7, 0 for chk=0 or chk=8; grant=1 ->
//     pend=0 the cycle after retire.
//  6. Push x0=32'hFFFF: macro on -> o_count stays 0, o_rd_wen stays 0;
//     macro off -> o_count=1, then an RF write to addr 0.

Source files
------------

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - in-order writeback queue feeding the single register-file write port
// Optional build macro: RF_WBQ_DROP_X0_EN (accept but discard writes to x0)
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_a_valid,
    output logic                     o_a_ready,
    input  logic [4:0]               i_a_waddr,
    input  logic [31:0]              i_a_wdata,
    input  logic                     i_b_valid,
    output logic                     o_b_ready,
    input  logic [4:0]               i_b_waddr,
    input  logic [31:0]              i_b_wdata,
    input  logic                     i_wb_grant,
    output logic                     o_rd_wen,
    output logic [4:0]               o_rd_waddr,
    output logic [31:0]              o_rd_wdata,
    input  logic [4:0]               i_rs1_chk,
    input  logic [4:0]               i_rs2_chk,
    output logic                     o_rs1_pend,
    output logic                     o_rs2_pend,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [4:0]    r_addr_mem [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_a_take;
    logic          w_b_take;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_push_addr;
    logic [31:0]   w_push_data;
    logic [PW-1:0] w_off   [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Readies are held low while reset is asserted, not just after it.
    assign o_a_ready = i_rst_n & ~w_full;
    assign o_b_ready = i_rst_n & ~w_full & ~i_a_valid;

    assign w_a_take    = i_a_valid & o_a_ready;
    assign w_b_take    = i_b_valid & o_b_ready;
    assign w_accept    = w_a_take | w_b_take;
    assign w_push_addr = i_a_valid ? i_a_waddr : i_b_waddr;
    assign w_push_data = i_a_valid ? i_a_wdata : i_b_wdata;

`ifdef RF_WBQ_DROP_X0_EN
    assign w_push = w_accept & (w_push_addr != 5'd0);
`else
    assign w_push = w_accept;
`endif

    assign w_pop      = ~w_empty & i_wb_grant;
    assign o_rd_wen   = w_pop;
    assign o_rd_waddr = w_empty ? 5'd0  : r_addr_mem[r_rd_ptr];
    assign o_rd_wdata = w_empty ? 32'd0 : r_data_mem[r_rd_ptr];

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

    // An entry is live when its distance from the head is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign w_off[g]   = PW'(g) - r_rd_ptr;
        assign w_valid[g] = (CW'(w_off[g]) < r_count);
        assign w_hit1[g]  = w_valid[g] & (r_addr_mem[g] == i_rs1_chk);
        assign w_hit2[g]  = w_valid[g] & (r_addr_mem[g] == i_rs2_chk);
    end

    assign o_rs1_pend = (i_rs1_chk != 5'd0) & (|w_hit1);
    assign o_rs2_pend = (i_rs2_chk != 5'd0) & (|w_hit2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr_mem[r_wr_ptr] <= w_push_addr;
                r_data_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb/tb_rf_wb_queue.sv - self-checking bench for rf_wb_queue with a queue-based reference model
module tb_rf_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_waddr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_waddr = '0;
    logic [31:0] b_wdata = '0;
    logic        grant = 1'b0;
    logic        rd_wen;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic [4:0]  rs1_chk = '0;
    logic [4:0]  rs2_chk = '0;
    logic        rs1_pend;
    logic        rs2_pend;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];

    rf_wb_queue #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_waddr(a_waddr), .i_a_wdata(a_wdata),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_waddr(b_waddr), .i_b_wdata(b_wdata),
        .i_wb_grant(grant), .o_rd_wen(rd_wen), .o_rd_waddr(rd_waddr), .o_rd_wdata(rd_wdata),
        .i_rs1_chk(rs1_chk), .i_rs2_chk(rs2_chk), .o_rs1_pend(rs1_pend), .o_rs2_pend(rs2_pend),
        .o_count(count), .o_full(full), .o_empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; a_waddr = 5'd3; rs1_chk = 5'd3; grant = 1'b1;
        #2;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%b exp=1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%b exp=0", full); end
        n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b%b exp=00", a_ready, b_ready); end
        n_tests++; if (rd_wen !== 1'b0 || rd_waddr !== 5'd0 || rd_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_port got=%b/%0d/%h exp=0/0/0", rd_wen, rd_waddr, rd_wdata); end
        n_tests++; if (rs1_pend !== 1'b0) begin n_fail++; $display("FAIL rst_pend got=%b exp=0", rs1_pend); end
        a_valid = 1'b0; grant = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_waddr = 5'(k + 3); a_wdata = 32'(k + 1);
            tick();
        end
        a_valid = 1'b0;
        #1;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL load3_count got=%0d exp=3", count); end
        grant = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (count !== 3'd0 || empty !== 1'b1 || rd_wen !== 1'b0) begin n_fail++; $display("FAIL midrst got count=%0d empty=%b wen=%b exp=0/1/0", count, empty, rd_wen); end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            n_tests++; if (rd_wen !== 1'b0) begin n_fail++; $display("FAIL postrst_wen got=%b exp=0", rd_wen); end
        end
        grant = 1'b0; rs1_chk = '0;
        tick();
    endtask

    task automatic test_single();
        grant = 1'b1; a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
        #2;
        n_tests++; if (a_ready !== 1'b1 || rd_wen !== 1'b0) begin n_fail++; $display("FAIL single_pre got ready=%b wen=%b exp=1/0", a_ready, rd_wen); end
        tick();
        a_valid = 1'b0;
        #2;
        n_tests++; if (rd_wen !== 1'b1 || rd_waddr !== 5'd5 || rd_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wr got=%b/%0d/%h exp=1/5/deadbeef", rd_wen, rd_waddr, rd_wdata); end
        tick();
        #2;
        n_tests++; if (empty !== 1'b1 || rd_wen !== 1'b0) begin n_fail++; $display("FAIL single_drain got empty=%b wen=%b exp=1/0", empty, rd_wen); end
        grant = 1'b0;
    endtask

    task automatic test_priority();
        grant = 1'b1;
        a_valid = 1'b1; a_waddr = 5'd1; a_wdata = 32'h11;
        b_valid = 1'b1; b_waddr = 5'd2; b_wdata = 32'h22;
        #2;
        n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready got=%b%b exp=10", a_ready, b_ready); end
        tick();
        a_valid = 1'b0;
        #2;
        n_tests++; if (b_ready !== 1'b1 || rd_wen !== 1'b1 || rd_waddr !== 5'd1 || rd_wdata !== 32'h11) begin n_fail++; $display("FAIL prio_first got bready=%b wr=%b/%0d/%h exp=1 1/1/11", b_ready, rd_wen, rd_waddr, rd_wdata); end
        tick();
        b_valid = 1'b0;
        #2;
        n_tests++; if (rd_wen !== 1'b1 || rd_waddr !== 5'd2 || rd_wdata !== 32'h22) begin n_fail++; $display("FAIL prio_second got=%b/%0d/%h exp=1/2/22", rd_wen, rd_waddr, rd_wdata); end
        tick();
        #2;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL prio_drain got empty=%b exp=1", empty); end
        grant = 1'b0;
    endtask

    task automatic test_full();
        logic [4:0] exp_addr [4];
        exp_addr[0] = 5'd11; exp_addr[1] = 5'd12; exp_addr[2] = 5'd13; exp_addr[3] = 5'd20;
        grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_waddr = 5'(10 + k); a_wdata = 32'(100 + k);
            tick();
        end
        a_waddr = 5'd20; a_wdata = 32'd200;
        #2;
        n_tests++; if (full !== 1'b1 || a_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_state got full=%b ready=%b count=%0d exp=1/0/4", full, a_ready, count); end
        tick();
        grant = 1'b1;
        #2;
        n_tests++; if (count !== 3'd4 || rd_wen !== 1'b1 || a_ready !== 1'b0 || rd_waddr !== 5'd10) begin n_fail++; $display("FAIL full_pop got count=%0d wen=%b ready=%b addr=%0d exp=4/1/0/10", count, rd_wen, a_ready, rd_waddr); end
        tick();
        grant = 1'b0;
        #2;
        n_tests++; if (count !== 3'd3 || a_ready !== 1'b1) begin n_fail++; $display("FAIL full_refused got count=%0d ready=%b exp=3/1", count, a_ready); end
        tick();
        a_valid = 1'b0;
        #2;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth got count=%0d exp=4", count); end
        grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++; if (rd_waddr !== exp_addr[k]) begin n_fail++; $display("FAIL full_order%0d got=%0d exp=%0d", k, rd_waddr, exp_addr[k]); end
            tick();
        end
        grant = 1'b0;
        #2;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain got empty=%b exp=1", empty); end
    endtask

    task automatic test_pend();
        grant = 1'b0;
        a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 32'd7;
        tick();
        a_valid = 1'b0;
        rs1_chk = 5'd7; rs2_chk = 5'd0;
        #2;
        n_tests++; if (rs1_pend !== 1'b1 || rs2_pend !== 1'b0) begin n_fail++; $display("FAIL pend_hit got=%b%b exp=10", rs1_pend, rs2_pend); end
        rs1_chk = 5'd8; rs2_chk = 5'd7;
        #1;
        n_tests++; if (rs1_pend !== 1'b0 || rs2_pend !== 1'b1) begin n_fail++; $display("FAIL pend_swap got=%b%b exp=01", rs1_pend, rs2_pend); end
        rs1_chk = 5'd7; grant = 1'b1;
        #1;
        n_tests++; if (rs1_pend !== 1'b1) begin n_fail++; $display("FAIL pend_preretire got=%b exp=1", rs1_pend); end
        tick();
        grant = 1'b0;
        #2;
        n_tests++; if (rs1_pend !== 1'b0 || rs2_pend !== 1'b0) begin n_fail++; $display("FAIL pend_retired got=%b%b exp=00", rs1_pend, rs2_pend); end
        rs1_chk = '0; rs2_chk = '0;
    endtask

    task automatic test_x0();
        grant = 1'b0;
        a_valid = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF;
        #2;
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%b exp=1", a_ready); end
        tick();
        a_valid = 1'b0;
        grant = 1'b1;
        #2;
`ifdef RF_WBQ_DROP_X0_EN
        n_tests++; if (count !== 3'd0 || rd_wen !== 1'b0) begin n_fail++; $display("FAIL x0_drop got count=%0d wen=%b exp=0/0", count, rd_wen); end
`else
        n_tests++; if (count !== 3'd1 || rd_wen !== 1'b1 || rd_waddr !== 5'd0 || rd_wdata !== 32'hFFFF) begin n_fail++; $display("FAIL x0_keep got count=%0d wr=%b/%0d/%h exp=1 1/0/ffff", count, rd_wen, rd_waddr, rd_wdata); end
`endif
        tick();
        grant = 1'b0;
        #2;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL x0_drain got empty=%b exp=1", empty); end
    endtask

    task automatic test_random();
        int   sz;
        logic e_ar, e_br, e_wen, e_p1, e_p2, a_acc, b_acc;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic a_hold = 1'b0;
        logic b_hold = 1'b0;
        int   errs = 0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        mq.delete();
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!a_hold) begin
                a_valid = 1'($urandom_range(0, 1));
                a_waddr = 5'($urandom_range(0, 7));
                a_wdata = $urandom;
            end
            if (!b_hold) begin
                b_valid = 1'($urandom_range(0, 1));
                b_waddr = 5'($urandom_range(0, 7));
                b_wdata = $urandom;
            end
            grant   = ($urandom_range(0, 3) == 0);
            rs1_chk = 5'($urandom_range(0, 7));
            rs2_chk = 5'($urandom_range(0, 7));
            #2;
            sz    = mq.size();
            e_ar  = (sz < DEPTH);
            e_br  = e_ar && !a_valid;
            e_wen = (sz > 0) && grant;
            e_addr = (sz > 0) ? mq[0].addr : 5'd0;
            e_data = (sz > 0) ? mq[0].data : 32'd0;
            e_p1 = 1'b0; e_p2 = 1'b0;
            foreach (mq[i]) begin
                if (rs1_chk != 0 && mq[i].addr == rs1_chk) e_p1 = 1'b1;
                if (rs2_chk != 0 && mq[i].addr == rs2_chk) e_p2 = 1'b1;
            end
            n_tests++;
            if (a_ready !== e_ar || b_ready !== e_br || rd_wen !== e_wen || rd_waddr !== e_addr ||
                rd_wdata !== e_data || rs1_pend !== e_p1 || rs2_pend !== e_p2 || count !== 3'(sz) ||
                full !== (sz == DEPTH) || empty !== (sz == 0)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_cyc%0d got rdy=%b%b wr=%b/%0d/%h pend=%b%b cnt=%0d exp rdy=%b%b wr=%b/%0d/%h pend=%b%b cnt=%0d",
                             cyc, a_ready, b_ready, rd_wen, rd_waddr, rd_wdata, rs1_pend, rs2_pend, count,
                             e_ar, e_br, e_wen, e_addr, e_data, e_p1, e_p2, sz);
            end
            a_acc = a_valid && e_ar;
            b_acc = b_valid && e_br;
            if (e_wen) void'(mq.pop_front());
            if (a_acc || b_acc) begin
`ifdef RF_WBQ_DROP_X0_EN
                if ((a_acc ? a_waddr : b_waddr) != 5'd0)
                    mq.push_back(a_acc ? ent_t'{a_waddr, a_wdata} : ent_t'{b_waddr, b_wdata});
`else
                mq.push_back(a_acc ? ent_t'{a_waddr, a_wdata} : ent_t'{b_waddr, b_wdata});
`endif
            end
            a_hold = a_valid && !a_acc;
            b_hold = b_valid && !b_acc;
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0; grant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_full();
        test_pend();
        test_x0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
